da_gemm_engine: RTL

//   Bit-serial distributed-arithmetic GEMM engine: C[m][n] = sat(rnd((sum_k A[m][k]*B[k][n] + bias[n]) >>> OUT_SHIFT)).

---
 rtl/da_gemm_engine.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/da_gemm_engine.sv
// da_gemm_engine: bit-serial distributed-arithmetic GEMM engine.
// Computes C[m][n] = sat(rnd((sum_k A[m][k]*B[k][n] + bias[n]) >>> OUT_SHIFT)).
// Each output row takes W compute cycles (one bit of A per cycle) and then one output cycle.
// Ports:
//   clk, rst (async, active-high), clear (sync abort to idle)
//   in_valid/in_ready : job handshake; A, B, bias and bias_en are captured when both are high
//   A    : M*K elements of DATA_WIDTH_A, element (m,k) at [(m*K+k)*DATA_WIDTH_A +: DATA_WIDTH_A]
//   B    : K*N elements of DATA_WIDTH_B, element (k,n) at [(k*N+n)*DATA_WIDTH_B +: DATA_WIDTH_B]
//   bias : N elements of DATA_WIDTH_BIAS, element n at [n*DATA_WIDTH_BIAS +: DATA_WIDTH_BIAS]
//   out_valid/out_ready : result row handshake; out_row is the row index, out_data holds N elements
//   out_sat : some column of the row was clamped; busy : not idle; done : last row was accepted
module da_gemm_engine #(
    parameter int DATA_WIDTH_A    = 8,
    parameter int DATA_WIDTH_B    = 8,
    parameter int DATA_WIDTH_BIAS = 16,
    parameter int DATA_WIDTH_OUT  = 8,
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int K               = 16,
    parameter int OUT_SHIFT       = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   bias_en,
    input  logic [M*K*DATA_WIDTH_A-1:0]            A,
    input  logic [K*N*DATA_WIDTH_B-1:0]            B,
    input  logic [N*DATA_WIDTH_BIAS-1:0]           bias,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [(M > 1 ? $clog2(M) : 1)-1:0]     out_row,
    output logic [N*DATA_WIDTH_OUT-1:0]            out_data,
    output logic                                   out_sat,
    output logic                                   busy,
    output logic                                   done
);
    localparam int W     = DATA_WIDTH_A;
    localparam int TW    = (W > 1) ? $clog2(W) : 1;
    localparam int MW    = (M > 1) ? $clog2(M) : 1;
    localparam int ACC_W = DATA_WIDTH_A + DATA_WIDTH_B + $clog2(K) + 1;
    // Headroom for the bias add and the rounding offset.
    localparam int SW    = ((ACC_W > DATA_WIDTH_BIAS) ? ACC_W : DATA_WIDTH_BIAS) + 2;
    localparam logic signed [SW-1:0] RND  = (SW'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [SW-1:0] OMAX = SW'((1 << (DATA_WIDTH_OUT - 1)) - 1);
    localparam logic signed [SW-1:0] OMIN = ~OMAX;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] OUTPUT  = 2'd2;

    logic [1:0]                       state;
    logic [TW-1:0]                    t;
    logic [MW-1:0]                    m;
    logic [W-1:0]                     a_q    [M][K];
    logic [DATA_WIDTH_B-1:0]          b_q    [K][N];
    logic [DATA_WIDTH_BIAS-1:0]       bias_q [N];
    logic                             bias_en_q;
    logic signed [ACC_W-1:0]          acc_q  [N];
    logic signed [ACC_W-1:0]          acc_nx [N];
    logic [DATA_WIDTH_OUT-1:0]        res_c  [N];
    logic [N-1:0]                     sat_c;
    logic signed [ACC_W-1:0]          p_c;
    logic signed [ACC_W-1:0]          sh_c;
    logic signed [SW-1:0]             x_c;
    logic signed [SW-1:0]             y_c;
    logic                             last_bit;

    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign last_bit = t == TW'(W - 1);

    // The MSB of A carries negative weight, so the last bit-plane is subtracted.
    always_comb begin
        p_c   = '0;
        sh_c  = '0;
        x_c   = '0;
        y_c   = '0;
        sat_c = '0;
        for (int n = 0; n < N; n++) begin
            p_c = '0;
            for (int k = 0; k < K; k++)
                p_c = p_c + (a_q[m][k][t] ? ACC_W'($signed(b_q[k][n])) : ACC_W'(0));
            sh_c      = p_c <<< t;
            acc_nx[n] = last_bit ? acc_q[n] - sh_c : acc_q[n] + sh_c;
            x_c       = SW'(acc_nx[n]) + (bias_en_q ? SW'($signed(bias_q[n])) : SW'(0)) + RND;
            y_c       = x_c >>> OUT_SHIFT;
            sat_c[n]  = (y_c > OMAX) || (y_c < OMIN);
            res_c[n]  = (y_c > OMAX) ? OMAX[DATA_WIDTH_OUT-1:0] :
                        (y_c < OMIN) ? OMIN[DATA_WIDTH_OUT-1:0] : y_c[DATA_WIDTH_OUT-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            m         <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            done      <= 1'b0;
            bias_en_q <= 1'b0;
            for (int n = 0; n < N; n++) begin
                acc_q[n]  <= '0;
                bias_q[n] <= '0;
            end
            for (int i = 0; i < M; i++)
                for (int k = 0; k < K; k++)
                    a_q[i][k] <= '0;
            for (int k = 0; k < K; k++)
                for (int n = 0; n < N; n++)
                    b_q[k][n] <= '0;
        end else if (clear) begin
            state     <= IDLE;
            t         <= '0;
            m         <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    state     <= COMPUTE;
                    t         <= '0;
                    m         <= '0;
                    bias_en_q <= bias_en;
                    for (int n = 0; n < N; n++) begin
                        acc_q[n]  <= '0;
                        bias_q[n] <= bias[n*DATA_WIDTH_BIAS +: DATA_WIDTH_BIAS];
                    end
                    for (int i = 0; i < M; i++)
                        for (int k = 0; k < K; k++)
                            a_q[i][k] <= A[(i*K+k)*DATA_WIDTH_A +: DATA_WIDTH_A];
                    for (int k = 0; k < K; k++)
                        for (int n = 0; n < N; n++)
                            b_q[k][n] <= B[(k*N+n)*DATA_WIDTH_B +: DATA_WIDTH_B];
                end
                COMPUTE: begin
                    for (int n = 0; n < N; n++)
                        acc_q[n] <= acc_nx[n];
                    t <= last_bit ? '0 : t + 1'b1;
                    if (last_bit) begin
                        state     <= OUTPUT;
                        out_valid <= 1'b1;
                        out_row   <= m;
                        out_sat   <= |sat_c;
                        for (int n = 0; n < N; n++)
                            out_data[n*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] <= res_c[n];
                    end
                end
                OUTPUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    t         <= '0;
                    for (int n = 0; n < N; n++)
                        acc_q[n] <= '0;
                    if (m == MW'(M - 1)) begin
                        state <= IDLE;
                        m     <= '0;
                        done  <= 1'b1;
                    end else begin
                        state <= COMPUTE;
                        m     <= m + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
